// File: rtl/pe_feeder.sv
// Packs four narrow stream words into one 128-bit PE operand, launches the PE,
// waits for completion (bounded by TIMEOUT) and holds the captured result for a consumer.
module pe_feeder #(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [WORD_W-1:0]     s_data,
    output logic                  pe_valid,
    output logic [4*WORD_W-1:0]   pe_data,
    input  logic [127:0]          pe_result,
    input  logic                  pe_done,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [127:0]          m_data,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [1:0]            dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and data is stable while valid is held without ready.

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_FIRE = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t                state_q;
    logic [1:0]            idx_q;
    logic [1:0]            idx_d;
    logic [7:0]            wait_cnt_q;
    logic [7:0]            wait_cnt_d;
    logic                  pe_valid_q;
    logic                  m_valid_q;
    logic                  timeout_err_q;
    logic [4*WORD_W-1:0]   pe_data_q;
    logic [127:0]          m_data_q;

    assign idx_d      = idx_q + 2'd1;
    assign wait_cnt_d = wait_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_FILL;
            idx_q         <= 2'd0;
            wait_cnt_q    <= 8'd0;
            pe_valid_q    <= 1'b0;
            m_valid_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            pe_data_q     <= '0;
            m_data_q      <= '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (s_valid) begin
                        pe_data_q[idx_q*WORD_W +: WORD_W] <= s_data;
                        idx_q <= idx_d;
                        if (idx_q == 2'd3) begin
                            state_q    <= ST_FIRE;
                            pe_valid_q <= 1'b1;
                        end
                    end
                end
                ST_FIRE: begin
                    pe_valid_q <= 1'b0;
                    wait_cnt_q <= 8'd0;
                    state_q    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done on the last allowed cycle wins over the timeout.
                    if (pe_done) begin
                        m_data_q  <= pe_result;
                        m_valid_q <= 1'b1;
                        state_q   <= ST_OUT;
                    end else if (wait_cnt_q >= LAST_CNT) begin
                        m_data_q      <= pe_result;
                        m_valid_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_OUT;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                ST_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_FILL;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    assign s_ready     = (state_q == ST_FILL);
    assign busy        = (state_q != ST_FILL);
    assign pe_valid    = pe_valid_q;
    assign pe_data     = pe_data_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign timeout_err = timeout_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: packing, launch, done/timeout capture, backpressure,
// gapped input and asynchronous reset in the middle of an operation.
module tb_pe_feeder;

  logic         clk;
  logic         reset;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         pe_valid;
  logic [127:0] pe_data;
  logic [127:0] pe_result;
  logic         pe_done;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         busy;
  logic         timeout_err;
  logic [1:0]   dbg_state;

  int total;
  int bad;

  pe_feeder #(.WORD_W(32), .TIMEOUT(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .pe_valid    (pe_valid),
    .pe_data     (pe_data),
    .pe_result   (pe_result),
    .pe_done     (pe_done),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .timeout_err (timeout_err),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // checking
  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // driver tasks (inputs change on the falling edge)
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      bad++;
      total++;
      $error("FAIL send_word_timeout observed=%0d expected<50", n);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic send_group(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
    send_word(w0);
    send_word(w1);
    send_word(w2);
    send_word(w3);
  endtask

  task automatic drain;
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    pe_result = '0;
    pe_done   = 1'b0;
    m_ready   = 1'b0;

    // reset values, before any clock edge
    #3;
    chk1("rst_s_ready", s_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_pe_valid", pe_valid, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_timeout_err", timeout_err, 1'b0);
    chkw("rst_pe_data", pe_data, 128'h0);
    chkw("rst_m_data", m_data, 128'h0);
    chkw("rst_state", 128'(dbg_state), 128'(0));
    tick(2);
    reset = 1'b1;

    // normal operation, done 20 cycles after launch
    send_group(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    chk1("n_pe_valid_fire", pe_valid, 1'b1);
    chkw("n_state_fire", 128'(dbg_state), 128'(1));
    chkw("n_pe_data", pe_data, 128'h44444444_33333333_22222222_11111111);
    chk1("n_s_ready_fire", s_ready, 1'b0);
    chk1("n_busy_fire", busy, 1'b1);
    tick(1);
    chk1("n_pe_valid_drop", pe_valid, 1'b0);
    chkw("n_state_wait", 128'(dbg_state), 128'(2));
    tick(19);
    chk1("n_m_valid_before_done", m_valid, 1'b0);
    chkw("n_pe_data_hold", pe_data, 128'h44444444_33333333_22222222_11111111);
    pe_done   = 1'b1;
    pe_result = 128'hCAFE0001_00000000_00000000_0000BEEF;
    tick(1);
    pe_done   = 1'b0;
    pe_result = 128'h0;
    chk1("n_m_valid", m_valid, 1'b1);
    chkw("n_m_data", m_data, 128'hCAFE0001_00000000_00000000_0000BEEF);
    chk1("n_timeout_err", timeout_err, 1'b0);
    chkw("n_state_out", 128'(dbg_state), 128'(3));
    drain();
    chk1("n_m_valid_drop", m_valid, 1'b0);
    chk1("n_s_ready_back", s_ready, 1'b1);
    chk1("n_busy_idle", busy, 1'b0);

    // forced capture on WAIT cycle 23, then backpressure
    send_group(32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404);
    pe_result = 128'h7777_0000_1111_2222_3333_4444_5555_6666;
    tick(24);
    chk1("t_m_valid_cycle23", m_valid, 1'b0);
    chk1("t_err_before", timeout_err, 1'b0);
    tick(1);
    chk1("t_m_valid", m_valid, 1'b1);
    chk1("t_timeout_err", timeout_err, 1'b1);
    chkw("t_m_data", m_data, 128'h7777_0000_1111_2222_3333_4444_5555_6666);
    pe_result = 128'h1;
    s_valid   = 1'b1;
    s_data    = 32'hBADBAD00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk1("bp_m_valid", m_valid, 1'b1);
      chkw("bp_m_data", m_data, 128'h7777_0000_1111_2222_3333_4444_5555_6666);
      chk1("bp_s_ready", s_ready, 1'b0);
    end
    s_valid = 1'b0;
    s_data  = '0;
    drain();
    chk1("bp_s_ready_back", s_ready, 1'b1);
    chk1("bp_m_valid_drop", m_valid, 1'b0);
    chk1("bp_err_sticky", timeout_err, 1'b1);

    // gapped input: only handshaken words are packed
    begin
      logic [31:0] g [4];
      g[0] = 32'hA0A0A0A0;
      g[1] = 32'hB1B1B1B1;
      g[2] = 32'hC2C2C2C2;
      g[3] = 32'hD3D3D3D3;
      for (int k = 0; k < 4; k++) begin
        repeat ($urandom_range(0, 3)) begin
          s_valid = 1'b0;
          s_data  = $urandom;
          tick(1);
        end
        send_word(g[k]);
      end
      chk1("g_pe_valid", pe_valid, 1'b1);
      chkw("g_pe_data", pe_data, {g[3], g[2], g[1], g[0]});
    end
    tick(1);
    pe_done   = 1'b1;
    pe_result = 128'h5555;
    tick(1);
    pe_done   = 1'b0;
    chk1("g_m_valid", m_valid, 1'b1);
    chkw("g_m_data", m_data, 128'h5555);
    chk1("g_err_still_sticky", timeout_err, 1'b1);
    drain();

    // reset clears the sticky flag; done on the timeout cycle is a normal capture
    reset = 1'b0;
    #1;
    chk1("s_err_cleared", timeout_err, 1'b0);
    tick(1);
    reset = 1'b1;
    send_group(32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004);
    tick(24);
    chk1("s_m_valid_before", m_valid, 1'b0);
    pe_done   = 1'b1;
    pe_result = 128'h9999_8888;
    tick(1);
    pe_done   = 1'b0;
    chk1("s_m_valid", m_valid, 1'b1);
    chkw("s_m_data", m_data, 128'h9999_8888);
    chk1("s_timeout_err", timeout_err, 1'b0);
    drain();

    // reset while a result is pending discards it
    send_group(32'h0000000A, 32'h0000000B, 32'h0000000C, 32'h0000000D);
    tick(1);
    pe_done   = 1'b1;
    pe_result = 128'hDEAD;
    tick(1);
    pe_done = 1'b0;
    chk1("r_m_valid_pending", m_valid, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk1("r_m_valid_cleared", m_valid, 1'b0);
    chkw("r_m_data_cleared", m_data, 128'h0);
    chkw("r_pe_data_cleared", pe_data, 128'h0);
    chk1("r_s_ready", s_ready, 1'b1);
    chk1("r_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // reset after two words, then a fresh group
    send_word(32'hEEEE0000);
    send_word(32'hEEEE0001);
    #2;
    reset = 1'b0;
    #1;
    chkw("r2_pe_data_cleared", pe_data, 128'h0);
    chkw("r2_state", 128'(dbg_state), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    send_group(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978);
    chk1("r2_pe_valid", pe_valid, 1'b1);
    chkw("r2_pe_data", pe_data, 128'h4B5A6978_0F1E2D3C_9ABCDEF0_12345678);
    tick(3);
    chk1("r2_no_stale_result", m_valid, 1'b0);
    chkw("r2_state_wait", 128'(dbg_state), 128'(2));
    pe_done   = 1'b1;
    pe_result = 128'h4242;
    tick(1);
    pe_done = 1'b0;
    chk1("r2_m_valid", m_valid, 1'b1);
    chkw("r2_m_data", m_data, 128'h4242);
    drain();
    chk1("r2_m_valid_drop", m_valid, 1'b0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter: WORD_W, 32, width of the narrow input stream word.
REQ-002 Parameter: TIMEOUT, 24, maximum WAIT cycles before a forced capture; legal range 2..255.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: s_valid  input  1  input word valid.
REQ-006 Port: s_ready  output  1  feeder accepts a word this cycle.
REQ-007 Port: s_data  input  WORD_W  input word.
REQ-008 Port: pe_valid  output  1  one-cycle launch pulse to the downstream PE.
REQ-009 Port: pe_data  output  128  assembled operand to the PE.
REQ-010 Port: pe_result  input  128  PE result.
REQ-011 Port: pe_done  input  1  PE completion flag.
REQ-012 Port: m_valid  output  1  captured result available.
REQ-013 Port: m_ready  input  1  result consumer ready.
REQ-014 Port: m_data  output  128  captured result.
REQ-015 Port: busy  output  1  high in any state other than FILL.
REQ-016 Port: timeout_err  output  1  sticky flag; a capture was forced by TIMEOUT.

Function
REQ-017 The FSM SHALL have the states FILL, FIRE, WAIT and OUT, with FILL as the reset state.
REQ-018 In FILL, s_ready SHALL be 1; in all other states it SHALL be 0.
REQ-019 A word SHALL be accepted on any cycle with s_valid=1 and s_ready=1.
REQ-020 Accepted word k (k=0..3) SHALL be written to pe_data[32k+31:32k]; a 2-bit word index SHALL increment per accepted word and wrap 3->0.
REQ-021 On acceptance of word 3, the FSM SHALL move to FIRE on the next cycle.
REQ-022 In FIRE, pe_valid SHALL be 1 for exactly one cycle, after which the FSM SHALL move to WAIT with the wait counter at 0.
REQ-023 pe_data SHALL hold its value from FIRE until the next word-0 acceptance.
REQ-024 In WAIT, the wait counter SHALL increment by 1 each cycle.
REQ-025 If pe_done=1 in WAIT, pe_result SHALL be registered into m_data and the FSM SHALL move to OUT.
REQ-026 If the counter reaches TIMEOUT-1 with pe_done=0, pe_result SHALL be registered into m_data, timeout_err SHALL be set to 1, and the FSM SHALL move to OUT.
REQ-027 If pe_done=1 on the same cycle as the timeout condition, it SHALL count as a normal done capture and timeout_err SHALL NOT be set.
REQ-028 pe_done SHALL be ignored in FILL, FIRE and OUT.
REQ-029 In OUT, m_valid SHALL be 1, and m_data SHALL be held stable until m_valid=1 and m_ready=1.
REQ-030 On the m_valid/m_ready handshake cycle, the FSM SHALL move to FILL and m_valid SHALL drop on the next cycle.
REQ-031 Launch-to-capture latency SHALL be one cycle after the cycle in which pe_done is sampled high.
REQ-032 A new 4-word group SHALL NOT be accepted before the previous result has been handshaken out; at most one operation is in flight.
REQ-033 timeout_err SHALL be cleared only by reset.

Reset
REQ-034 Asserting reset (low) SHALL force, with no clock required: state=FILL, word index=0, wait counter=0, pe_valid=0, m_valid=0, timeout_err=0, pe_data=0, m_data=0.
REQ-035 s_ready SHALL be 1 and busy SHALL be 0 while reset is asserted.
REQ-036 Reset asserted mid-operation in any state SHALL abandon that operation; partially assembled words and any pending result SHALL be discarded.
REQ-037 After reset deasserts, the first accepted word SHALL be treated as word 0.

Verification
REQ-038 Scenario, normal operation: send words 0x11111111, 0x22222222, 0x33333333, 0x44444444, then pulse pe_done 20 cycles after pe_valid -> pe_data=0x44444444_33333333_22222222_11111111; pe_valid high for one cycle; m_data=pe_result; timeout_err=0.
REQ-039 Scenario, timeout: hold pe_done=0 with TIMEOUT=24 -> capture occurs on WAIT cycle 23; timeout_err=1 and remains 1 after further good operations.
REQ-040 Scenario, backpressure: hold m_ready=0 for 10 cycles in OUT -> m_valid stays 1, m_data is stable, s_ready=0; after m_ready=1, s_ready returns to 1 on the next cycle.
REQ-041 Scenario, gapped input: toggle s_valid randomly during FILL -> only handshaken words are packed, in order.
REQ-042 Scenario, simultaneous events: assert pe_done on WAIT cycle TIMEOUT-1 -> normal capture with timeout_err=0.
REQ-043 Scenario, reset mid-operation: assert reset after 2 words, then send 4 new words -> pe_data contains only the new words; the stale pending result is not emitted.
